// File: rtl/control_unit_if.sv
// control_unit_if: bundles the DataPath-facing signals of the control sequencer.
//
// Ports / signals:
//   IR         instruction register contents; opcode = IR[31:27]
//   mem_ready  memory finished the current Read/Write this cycle
//   stop       halt request, honoured at an instruction boundary
//   PCout, Zlowout, MDRout, Rout, BAout, Csignout   bus-drive strobes
//   PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin      register-load strobes
//   IncPC, ADD       ALU operation selects
//   Read, Write      memory strobes
//   Gra, Grb         register-field selects
//   run              high while executing
//
// Modports:
//   master  the control unit (drives strobes, observes IR/mem_ready/stop)
//   slave   the DataPath / memory side
interface control_unit_if;
  logic [31:0] IR;
  logic        mem_ready;
  logic        stop;

  logic PCout, Zlowout, MDRout, Rout, BAout, Csignout;
  logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin;
  logic IncPC, ADD;
  logic Read, Write;
  logic Gra, Grb;
  logic run;

  modport master (
    input  IR, mem_ready, stop,
    output PCout, Zlowout, MDRout, Rout, BAout, Csignout,
    output PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin,
    output IncPC, ADD, Read, Write, Gra, Grb, run
  );

  modport slave (
    output IR, mem_ready, stop,
    input  PCout, Zlowout, MDRout, Rout, BAout, Csignout,
    input  PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin,
    input  IncPC, ADD, Read, Write, Gra, Grb, run
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer driving every DataPath control strobe.
// Fetches an instruction (T0-T2), decodes IR[31:27] and steps through the
// T-state sequence for ld, ldi, st, addi and halt, one state per clock.
//
// Ports:
//   clock        system clock, rising edge
//   clear        asynchronous active-low reset
//   bus          control_unit_if.master (IR, mem_ready, stop in; strobes, run out)
//   dbg_state_o  current FSM state encoding, for observation only
//
// Memory handshake: in a memory-wait state (T1, ld-T6, st-T7) the state's
// strobes act as the request and stay asserted; mem_ready is the completion
// signal, and the state advances on the first rising edge where mem_ready=1.
// In all other states mem_ready is ignored and the state lasts one cycle.
module control_unit (
  input  logic                 clock,
  input  logic                 clear,
  control_unit_if.master       bus,
  output logic [3:0]           dbg_state_o
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [4:0] ir_op;
  state_e     boundary_next;

  // Only the opcode field is decoded here; the rest of IR belongs to the DataPath.
  logic ir_unused;
  assign ir_unused = ^bus.IR[26:0];

  assign ir_op       = bus.IR[31:27];
  assign dbg_state_o = state_q;

  // Every transition that would start a new fetch checks stop first.
  assign boundary_next = bus.stop ? S_HALT : S_T0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_RST;
      op_q    <= 5'b00000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RST: state_d = boundary_next;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = bus.mem_ready ? S_T2 : S_T1;
      S_T2: begin
        case (ir_op)
          OP_HALT: state_d = S_HALT;
          OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
            state_d = S_T3;
            op_d    = ir_op;
          end
          // Unrecognised opcodes retire as a no-op straight after fetch.
          default: state_d = boundary_next;
        endcase
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        if (op_q == OP_LD || op_q == OP_ST) state_d = S_T6;
        else                                state_d = boundary_next;
      end
      S_T6: begin
        if (op_q == OP_LD) state_d = bus.mem_ready ? S_T7 : S_T6;
        else               state_d = S_T7;
      end
      S_T7: begin
        if (op_q == OP_ST) state_d = bus.mem_ready ? boundary_next : S_T7;
        else               state_d = boundary_next;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Moore output decode: strobes depend on state and latched opcode only.
  always_comb begin
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.MDRout   = 1'b0;
    bus.Rout     = 1'b0;
    bus.BAout    = 1'b0;
    bus.Csignout = 1'b0;
    bus.PCin     = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zlowin   = 1'b0;
    bus.Rin      = 1'b0;
    bus.IncPC    = 1'b0;
    bus.ADD      = 1'b0;
    bus.Read     = 1'b0;
    bus.Write    = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.run      = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      S_T1: begin
        // PCin repeats while waiting; harmless since Z is not reloaded.
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        bus.Grb = 1'b1;
        bus.Yin = 1'b1;
        // addi takes the base from the register file; the others use BA
        // so that register 0 reads as zero for address formation.
        if (op_q == OP_ADDI) bus.Rout  = 1'b1;
        else                 bus.BAout = 1'b1;
      end
      S_T4: begin
        bus.Csignout = 1'b1;
        bus.ADD      = 1'b1;
        bus.Zlowin   = 1'b1;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (op_q == OP_LD || op_q == OP_ST) begin
          bus.MARin = 1'b1;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end
      end
      S_T6: begin
        bus.MDRin = 1'b1;
        if (op_q == OP_LD) begin
          bus.Read = 1'b1;
        end else begin
          // Read stays low so MDR loads from the bus, not from memory.
          bus.Gra  = 1'b1;
          bus.Rout = 1'b1;
        end
      end
      S_T7: begin
        bus.MDRout = 1'b1;
        if (op_q == OP_LD) begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end else begin
          bus.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
